adpll_cfg_ctrl: RTL and testbench
=================================

# adpll_cfg_ctrl

Parameter-programming controller for the 5-bit ADPLL loop. It synchronizes the asynchronous `clr`/`pgm` pad controls and sequences writes of `pgm_value` into an 8-entry × 5-bit parameter bank. It drives the loop gains, DCO offset, divider ratio and lock thresholds consumed by the TDC, PI filter, DCO and divider. It also freezes the loop (`loop_hold`) while parameters change and announces each commit with a one-cycle `cfg_update` pulse.

## Interface
- Parameters: none. Widths are fixed by the package: 5-bit data, 3-bit select.
- `clk`  in  1  sampling clock, 50 MHz
- `rst_n`  in  1  asynchronous, active-low reset
- `clr`  in  1  pad; rising edge restores all defaults
- `pgm`  in  1  pad; rising edge writes `pgm_value` to entry `param_sel`
- `param_sel`  in  3  entry index
- `pgm_value`  in  5  write data
- `kp`, `ki`, `dco_offset`, `div_n`, `tdc_gain`, `lock_thr`, `lock_cnt`, `ctrl`  out  5 each  bank entries 0..7
- `loop_hold`  out  1  freeze request to the PI filter
- `cfg_update`  out  1  one-cycle commit pulse
- `cfg_busy`  out  1  FSM not in IDLE
- `rd_data`  out  5  readback; present only with `ADPLL_CFG_READBACK_EN`

## Operation
- Synchronization:
  - `clr` and `pgm` each pass through a 2-flop synchronizer plus a third flop.
  - `*_rise = s2 & ~s3`.
  - `param_sel` and `pgm_value` are not synchronized. They are sampled in WRITE and must be stable from 3 cycles before `pgm` rises until WAIT_LOW is reached.
- Defaults (entry: value):
  - 0 KP = 4, 1 KI = 2, 2 DCO_OFFSET = 16, 3 DIV_N = 8
  - 4 TDC_GAIN = 1, 5 LOCK_THR = 2, 6 LOCK_CNT = 15, 7 CTRL = 0
- FSM states: IDLE, WRITE, CLEAR, COMMIT, WAIT_LOW.
  - IDLE: `clr_rise` or `clr_pend` → CLEAR, with index = 0. Otherwise `pgm_rise` → WRITE. `clr` has priority.
  - WRITE (1 cycle): bank[`param_sel`] ← `pgm_value`, then → COMMIT.
  - CLEAR (8 cycles): bank[idx] ← default[idx], idx++; after idx = 7 → COMMIT. `pgm_rise` is ignored here.
  - COMMIT (1 cycle): `cfg_update` = 1, then → WAIT_LOW.
  - WAIT_LOW: → IDLE when `pgm_s2` = 0. If `clr_rise` or `clr_pend` → CLEAR.
- `clr_pend`:
  - Set by `clr_rise` occurring in WRITE, COMMIT or CLEAR.
  - Cleared on entry to CLEAR.
  - A `clr_rise` during CLEAR therefore causes exactly one additional clear pass.
- Write coercion: a write of 0 to DIV_N stores 1. All other entries store the value verbatim; no arithmetic or saturation.
- `loop_hold` = 1 in WRITE, CLEAR and COMMIT, else 0.
- `cfg_busy` = 1 whenever state ≠ IDLE.
- Holding `pgm` high produces exactly one write. A second write needs `pgm` low, then high again.

## Timing
- Reset: bank = defaults, state = IDLE, synchronizers = 0, `clr_pend` = 0. `loop_hold`, `cfg_update`, `cfg_busy` = 0; `rd_data` = bank[0] = 4.
- Reset asserted mid-sequence aborts immediately, leaving the bank at defaults (no partial write).
- Write latency, with `pgm` high before edge E0:
  - `pgm_rise` at E2; WRITE during E2–E3.
  - New value visible after E3.
  - `cfg_update` high E3–E4.
  - `loop_hold` high E2–E4 (2 cycles).
- Clear: 8 CLEAR cycles plus 1 COMMIT, so `loop_hold` is high for 9 cycles. Entries update in index order, one per cycle.
- All outputs are registered, or decoded from registered state only.

## Configuration
- `ADPLL_CFG_READBACK_EN` defined:
  - Adds `rd_data` = bank[`param_sel`], registered with 1-cycle latency.
  - Top level routes it to spare `uo_out` bits via `out_sel`.
- Undefined: port `rd_data` and its mux are absent. No other behaviour changes.

## Structure
- Package `adpll_pkg`:
  - `PARAM_W` = 5, `SEL_W` = 3, `NPARAM` = 8.
  - Index constants `P_KP` … `P_CTRL`.
  - Default-value array.
  - State enum type.
- One sub-module: `adpll_sync_edge`, a 3-flop synchronizer with rising-edge output, instantiated twice (for `clr` and `pgm`).

## Test plan
- Reset release → all eight outputs equal defaults (4, 2, 16, 8, 1, 2, 15, 0); `cfg_busy` = 0.
- `param_sel` = 1, `pgm_value` = 9, `pgm` pulse → `ki` = 9 three edges after `pgm` sampled high. `cfg_update` pulses once; `loop_hold` is high for exactly 2 cycles.
- `param_sel` = 3, `pgm_value` = 0 → `div_n` = 1; a later write of 0 to `kp` gives `kp` = 0.
- Program `kp` = 31, then `clr` pulse → `kp` returns to 4 on the first CLEAR cycle. `loop_hold` is high for 9 cycles; `cfg_update` pulses once at the end.
- `clr` and `pgm` rising on the same cycle → CLEAR only; the write is dropped. `clr` rising during WRITE → write completes, then one clear pass follows WAIT_LOW.
- `pgm` held high for 100 cycles → exactly one `cfg_update`. With `ADPLL_CFG_READBACK_EN`: `param_sel` = 2 gives `rd_data` = 16 one cycle later.

Source files
------------

// File: rtl/adpll_pkg.sv
// Shared widths, parameter-bank indices, reset defaults and FSM state type
// for the ADPLL configuration controller.
package adpll_pkg;

  localparam int PARAM_W = 5;
  localparam int SEL_W   = 3;
  localparam int NPARAM  = 8;

  typedef logic [PARAM_W-1:0] param_t;
  typedef logic [SEL_W-1:0]   sel_t;

  localparam sel_t P_KP         = 3'd0;
  localparam sel_t P_KI         = 3'd1;
  localparam sel_t P_DCO_OFFSET = 3'd2;
  localparam sel_t P_DIV_N      = 3'd3;
  localparam sel_t P_TDC_GAIN   = 3'd4;
  localparam sel_t P_LOCK_THR   = 3'd5;
  localparam sel_t P_LOCK_CNT   = 3'd6;
  localparam sel_t P_CTRL       = 3'd7;
  localparam sel_t P_LAST       = 3'd7;

  // Packed with entry 0 in the least significant slot, so PARAM_DEFAULT[i] is entry i.
  localparam param_t [NPARAM-1:0] PARAM_DEFAULT = {
    5'd0,   // CTRL
    5'd15,  // LOCK_CNT
    5'd2,   // LOCK_THR
    5'd1,   // TDC_GAIN
    5'd8,   // DIV_N
    5'd16,  // DCO_OFFSET
    5'd2,   // KI
    5'd4    // KP
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_CLEAR,
    S_COMMIT,
    S_WAIT_LOW
  } state_e;

  // A zero divider ratio would stall the feedback divider, so it is stored as 1.
  function automatic param_t coerce_write(input sel_t sel, input param_t value);
    if (sel == P_DIV_N && value == '0) return param_t'(1);
    return value;
  endfunction

endpackage

// File: rtl/adpll_sync_edge.sv
// Two-flop synchronizer for an asynchronous pad, plus a third flop to detect
// the rising edge of the synchronized level.
module adpll_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic s2_o,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q;

  // NOTE: sequential state uses non-blocking assignments so each flop samples
  // the previous value of its neighbour, forming a true shift chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign s2_o   = s2_q;
  assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/adpll_cfg_ctrl.sv
// ADPLL parameter-bank programming controller: synchronized clr/pgm pads,
// write/clear sequencing, loop freeze and commit pulse.
// Optional readback port enabled by defining ADPLL_CFG_READBACK_EN.
module adpll_cfg_ctrl
  import adpll_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               pgm,
  input  logic [SEL_W-1:0]   param_sel,
  input  logic [PARAM_W-1:0] pgm_value,
  output logic [PARAM_W-1:0] kp,
  output logic [PARAM_W-1:0] ki,
  output logic [PARAM_W-1:0] dco_offset,
  output logic [PARAM_W-1:0] div_n,
  output logic [PARAM_W-1:0] tdc_gain,
  output logic [PARAM_W-1:0] lock_thr,
  output logic [PARAM_W-1:0] lock_cnt,
  output logic [PARAM_W-1:0] ctrl,
  output logic               loop_hold,
  output logic               cfg_update,
  output logic               cfg_busy
`ifdef ADPLL_CFG_READBACK_EN
  ,
  output logic [PARAM_W-1:0] rd_data
`endif
);

  logic clr_rise, clr_s2_unused;
  logic pgm_rise, pgm_s2;

  adpll_sync_edge u_sync_clr (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (clr),
    .s2_o   (clr_s2_unused),
    .rise_o (clr_rise)
  );

  adpll_sync_edge u_sync_pgm (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (pgm),
    .s2_o   (pgm_s2),
    .rise_o (pgm_rise)
  );

  state_e                  state_q, state_d;
  sel_t                    idx_q, idx_d;
  logic                    pend_q, pend_d;
  param_t [NPARAM-1:0]     bank_q;
  logic                    bank_we;
  sel_t                    bank_waddr;
  param_t                  bank_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
    end
  end

  // NOTE: every signal gets a default before the case, so no path through the
  // block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pend_d     = pend_q;
    bank_we    = 1'b0;
    bank_waddr = param_sel;
    bank_wdata = coerce_write(param_sel, pgm_value);

    unique case (state_q)
      S_IDLE: begin
        if (clr_rise || pend_q) begin
          state_d = S_CLEAR;
          idx_d   = '0;
          pend_d  = 1'b0;
        end else if (pgm_rise) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        bank_we = 1'b1;
        state_d = S_COMMIT;
        if (clr_rise) pend_d = 1'b1;
      end
      S_CLEAR: begin
        // pgm_rise is deliberately ignored while defaults are restored.
        bank_we    = 1'b1;
        bank_waddr = idx_q;
        bank_wdata = PARAM_DEFAULT[idx_q];
        idx_d      = idx_q + 3'd1;
        if (idx_q == P_LAST) state_d = S_COMMIT;
        if (clr_rise) pend_d = 1'b1;
      end
      S_COMMIT: begin
        state_d = S_WAIT_LOW;
        if (clr_rise) pend_d = 1'b1;
      end
      S_WAIT_LOW: begin
        if (clr_rise || pend_q) begin
          state_d = S_CLEAR;
          idx_d   = '0;
          pend_d  = 1'b0;
        end else if (!pgm_s2) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the bank is eight flop registers rather than a RAM macro, so it can
  // take an asynchronous reset straight to the defaults.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= PARAM_DEFAULT;
    end else if (bank_we) begin
      bank_q[bank_waddr] <= bank_wdata;
    end
  end

  assign kp         = bank_q[P_KP];
  assign ki         = bank_q[P_KI];
  assign dco_offset = bank_q[P_DCO_OFFSET];
  assign div_n      = bank_q[P_DIV_N];
  assign tdc_gain   = bank_q[P_TDC_GAIN];
  assign lock_thr   = bank_q[P_LOCK_THR];
  assign lock_cnt   = bank_q[P_LOCK_CNT];
  assign ctrl       = bank_q[P_CTRL];

  assign loop_hold  = (state_q == S_WRITE) || (state_q == S_CLEAR) || (state_q == S_COMMIT);
  assign cfg_update = (state_q == S_COMMIT);
  assign cfg_busy   = (state_q != S_IDLE);

`ifdef ADPLL_CFG_READBACK_EN
  param_t rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= PARAM_DEFAULT[P_KP];
    end else begin
      rd_q <= bank_q[param_sel];
    end
  end

  assign rd_data = rd_q;
`endif

endmodule

// File: tb/tb_adpll_cfg_ctrl.sv
// Scoreboard bench for adpll_cfg_ctrl: stimulus pushes the expected bank and
// loop_hold length per commit; a monitor pops and compares on each cfg_update.
`timescale 1ns/1ps
module tb_adpll_cfg_ctrl;

  typedef logic [7:0][4:0] bank_t;
  typedef struct packed {
    logic [31:0] id;
    bank_t       bank;
    logic [31:0] hold;
  } exp_t;

  // Listed from entry 7 down to entry 0: CTRL .. KP.
  localparam bank_t DEF = {5'd0, 5'd15, 5'd2, 5'd1, 5'd8, 5'd16, 5'd2, 5'd4};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       pgm = 1'b0;
  logic [2:0] param_sel = '0;
  logic [4:0] pgm_value = '0;
  logic [4:0] kp, ki, dco_offset, div_n, tdc_gain, lock_thr, lock_cnt, ctrl;
  logic       loop_hold, cfg_update, cfg_busy;
`ifdef ADPLL_CFG_READBACK_EN
  logic [4:0] rd_data;
`endif

  adpll_cfg_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .pgm        (pgm),
    .param_sel  (param_sel),
    .pgm_value  (pgm_value),
    .kp         (kp),
    .ki         (ki),
    .dco_offset (dco_offset),
    .div_n      (div_n),
    .tdc_gain   (tdc_gain),
    .lock_thr   (lock_thr),
    .lock_cnt   (lock_cnt),
    .ctrl       (ctrl),
    .loop_hold  (loop_hold),
    .cfg_update (cfg_update),
    .cfg_busy   (cfg_busy)
`ifdef ADPLL_CFG_READBACK_EN
    ,
    .rd_data    (rd_data)
`endif
  );

  always #5 clk = ~clk;

  int    tests = 0;
  int    fails = 0;
  int    n_pushed = 0;
  int    n_updates = 0;
  int    hold_run = 0;
  bank_t model;
  exp_t  sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bank_t dut_bank();
    return {ctrl, lock_cnt, lock_thr, tdc_gain, div_n, dco_offset, ki, kp};
  endfunction

  task automatic push_exp(input int hold);
    exp_t e;
    e.id   = n_pushed;
    e.bank = model;
    e.hold = hold;
    sb_q.push_back(e);
    n_pushed++;
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_run = 0;
    end else begin
      if (loop_hold) hold_run++;
      else hold_run = 0;
      if (cfg_update) begin
        n_updates++;
        check("update_expected", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          exp_t  e;
          bank_t got;
          e   = sb_q.pop_front();
          got = dut_bank();
          for (int i = 0; i < 8; i++)
            check($sformatf("upd%0d_entry%0d", e.id, i), got[i], e.bank[i]);
          check($sformatf("upd%0d_hold_len", e.id), hold_run, e.hold);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (cfg_busy && n < 200);
    check("idle_reached", cfg_busy, 0);
  endtask

  task automatic setup(input logic [2:0] sel, input logic [4:0] val);
    param_sel = sel;
    pgm_value = val;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pgm_write(input logic [2:0] sel, input logic [4:0] val, input int hold_cycles);
    setup(sel, val);
    model[sel] = (sel == 3'd3 && val == 5'd0) ? 5'd1 : val;
    push_exp(2);
    pgm = 1'b1;
    repeat (hold_cycles) @(posedge clk);
    #1 pgm = 1'b0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model = DEF;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    check("rst_bank", dut_bank(), DEF);
    check("rst_busy", cfg_busy, 0);
    check("rst_hold", loop_hold, 0);
    check("rst_update", cfg_update, 0);
`ifdef ADPLL_CFG_READBACK_EN
    check("rst_rd_data", rd_data, 4);
`endif

    // ki = 9 with edge-exact latency
    setup(3'd1, 5'd9);
    model[1] = 5'd9;
    push_exp(2);
    pgm = 1'b1;
    repeat (3) @(posedge clk);  // E0, E1, E2
    #1;
    check("ki_before_E3", ki, 2);
    check("hold_in_write", loop_hold, 1);
    @(posedge clk); #1;         // E3
    check("ki_after_E3", ki, 9);
    check("update_at_E3", cfg_update, 1);
    repeat (2) @(posedge clk);
    #1 pgm = 1'b0;
    wait_idle();

    // Coercion of DIV_N, verbatim zero elsewhere
    pgm_write(3'd3, 5'd0, 4);
    check("div_n_coerced", div_n, 1);
    pgm_write(3'd0, 5'd0, 4);
    check("kp_zero", kp, 0);

    // kp = 31 then clear; kp restored on first CLEAR cycle, in index order
    pgm_write(3'd0, 5'd31, 4);
    model = DEF;
    push_exp(9);
    clr = 1'b1;
    repeat (3) @(posedge clk);  // CLEAR entered at E2
    #1;
    check("kp_before_clear_write", kp, 31);
    @(posedge clk); #1;
    check("kp_first_clear_cycle", kp, 4);
    check("ki_not_yet_cleared", ki, 9);
    clr = 1'b0;
    wait_idle();

    // clr and pgm rising together: clear only, write dropped
    pgm_write(3'd5, 5'd7, 4);
    setup(3'd6, 5'd3);
    model = DEF;
    push_exp(9);
    clr = 1'b1;
    pgm = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    clr = 1'b0;
    pgm = 1'b0;
    wait_idle();
    check("simul_lock_cnt", lock_cnt, 15);

    // clr rising during WRITE: write commits, then one clear pass
    setup(3'd4, 5'd20);
    model[4] = 5'd20;
    push_exp(2);
    model = DEF;
    push_exp(9);
    pgm = 1'b1;
    @(posedge clk); #1;
    clr = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    clr = 1'b0;
    pgm = 1'b0;
    wait_idle();
    check("after_write_clear_tdc", tdc_gain, 1);

    // clr rising during CLEAR: exactly one extra pass
    pgm_write(3'd2, 5'd3, 4);
    model = DEF;
    push_exp(9);
    push_exp(9);
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b1;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    wait_idle();

    // pgm held 100 cycles: one write, one commit
    pgm_write(3'd7, 5'd5, 100);
    check("ctrl_held", ctrl, 5);

    // Reset in the middle of a write leaves defaults
    setup(3'd0, 5'd17);
    pgm = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("busy_in_write", cfg_busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_bank", dut_bank(), DEF);
    check("abort_busy", cfg_busy, 0);
    pgm = 1'b0;
    model = DEF;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_abort_kp", kp, 4);

`ifdef ADPLL_CFG_READBACK_EN
    param_sel = 3'd2;
    @(posedge clk); #1;
    check("rd_dco_offset", rd_data, 16);
    param_sel = 3'd6;
    @(posedge clk); #1;
    check("rd_lock_cnt", rd_data, 15);
`endif

    repeat (5) @(posedge clk);
    #1;
    check("sb_drained", sb_q.size(), 0);
    check("update_count", n_updates, n_pushed);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
